rpsls_match_referee: RTL and testbench
======================================

Name: rpsls_match_referee

Overview:
- Sequential match referee for rock/paper/scissors/lizard/spock.
- Accepts one pair of player moves per round over a valid/ready handshake and judges each round.
- Keeps per-player score counters and declares a match winner when either player reaches ROUNDS_TO_WIN.
- Sits between the player input logic (switches/encoders) and the display/LED driver. It generalises the combinational single-round judge to a registered, multi-round match with invalid-move detection.

Parameters:
- ROUNDS_TO_WIN, 3, round wins needed to take the match (1..2**SCORE_W-1).
- SCORE_W, 3, width of each score counter.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- new_match  input  1  single-cycle pulse; clears scores and starts a new match
- player1  input  3  player 1 move code
- player2  input  3  player 2 move code
- move_valid  input  1  moves on player1/player2 are valid this cycle
- move_ready  output  1  referee can accept a move pair this cycle
- round_valid  output  1  one-cycle pulse; round result outputs are valid
- p1wins  output  1  round result: player 1 won (qualified by round_valid)
- p2wins  output  1  round result: player 2 won
- tied  output  1  round result: tie
- invalid  output  1  round rejected; a move code was not 1..5
- p1_score  output  SCORE_W  player 1 rounds won this match
- p2_score  output  SCORE_W  player 2 rounds won this match
- match_over  output  1  level; match decided
- match_winner  output  2  00 none, 01 player 1, 10 player 2

Behaviour:
- Move codes: ROCK=1, PAPER=2, SCISSORS=3, LIZARD=4, SPOCK=5; codes 0, 6 and 7 are invalid.
- Win pairs (p1 beats p2): R>S, R>L, P>R, P>K, S>P, S>L, L>P, L>K, K>R, K>S.
- Reset value of every output is 0 except move_ready=1. State after reset is READY.
- FSM states:
  - READY: move_ready=1. On move_valid&&move_ready, register player1/player2 and go to RESULT.
  - RESULT: move_ready=0. round_valid=1 for exactly this cycle, and exactly one of p1wins/p2wins/tied/invalid is 1.
    - Score increment is applied on the RESULT->next edge.
    - If the incremented score equals ROUNDS_TO_WIN, go to DONE; otherwise go to READY.
  - DONE: move_ready=0, match_over=1, match_winner held. move_valid is ignored.
- Latency: accept edge -> round_valid high in the following cycle. Scores are visible one cycle after round_valid. Peak throughput is one round per 2 cycles.
- Round outputs (p1wins/p2wins/tied/invalid) are registered and forced to 0 whenever round_valid=0.
- Invalid round: invalid=1, p1wins/p2wins/tied=0, scores unchanged, return to READY. A pair where both codes are invalid and equal is still invalid, not tied.
- Tie: no score change.
- new_match has priority in every state: scores, match_over and match_winner clear on the next edge; state goes to READY. A move_valid in the same cycle is not accepted. A new_match during RESULT suppresses that round's score update.
- Scores never exceed ROUNDS_TO_WIN, so no wrap is possible.
- reset asserted mid-round aborts the round immediately (asynchronous); no round_valid pulse is produced.

Optional Feature:
- Macro: RPSLS_TIE_LIMIT_EN.
- Defined:
  - Adds parameter MAX_TIES (default 4) and output tie_count[SCORE_W-1:0], incremented on each tied round and cleared by new_match/reset.
  - When tie_count reaches MAX_TIES, go to DONE with match_over=1 and match_winner=11 (draw).
- Undefined: no tie counter and no tie_count port; ties never end a match, and match_winner is never 11.

Decomposition:
- Package rpsls_pkg:
  - move code constants;
  - state encoding (READY, RESULT, DONE);
  - match_winner encodings (NONE, P1, P2, DRAW).
- Sub-module rpsls_round_judge: purely combinational, takes two 3-bit codes and returns p1wins/p2wins/tied/invalid. The referee instantiates it on the registered moves.

Test Plan:
- Reset, then p1=ROCK(1), p2=SCISSORS(3), move_valid for 1 cycle -> round_valid pulses the next cycle with p1wins=1, and p1_score=1 one cycle later.
- Three rounds of p1=LIZARD(4), p2=SPOCK(5) with ROUNDS_TO_WIN=3 -> p1_score=3, match_over=1, match_winner=01, move_ready=0; a fourth move_valid is ignored.
- p1=6, p2=2 -> round_valid with invalid=1 and all other flags 0, scores unchanged. Then p1=0, p2=0 -> invalid=1, tied=0.
- p1=PAPER, p2=PAPER -> tied=1, scores stay 0/0. Then new_match asserted in the same cycle as move_valid -> move not accepted and scores 0/0.
- In DONE, pulse new_match -> next cycle match_over=0, match_winner=00, scores 0, move_ready=1. Assert reset asynchronously during RESULT -> outputs clear without waiting for a clock edge.
- With RPSLS_TIE_LIMIT_EN and MAX_TIES=4, four SPOCK/SPOCK rounds -> tie_count=4, match_over=1, match_winner=11.

Source files
------------

// File: rtl/rpsls_pkg.sv
// Shared types for the rock/paper/scissors/lizard/spock match referee.
// Move codes, FSM state encoding and match winner encodings.
package rpsls_pkg;

  localparam logic [2:0] ROCK     = 3'd1;
  localparam logic [2:0] PAPER    = 3'd2;
  localparam logic [2:0] SCISSORS = 3'd3;
  localparam logic [2:0] LIZARD   = 3'd4;
  localparam logic [2:0] SPOCK    = 3'd5;

  typedef enum logic [1:0] {
    READY  = 2'd0,
    RESULT = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    W_NONE = 2'b00,
    W_P1   = 2'b01,
    W_P2   = 2'b10,
    W_DRAW = 2'b11
  } winner_t;

  function automatic logic is_move(logic [2:0] m);
    return (m >= ROCK) && (m <= SPOCK);
  endfunction

endpackage

// File: rtl/rpsls_match_referee_if.sv
// Move handshake and result bundle between players and referee.
// tie_count exists only when RPSLS_TIE_LIMIT_EN is defined.
interface rpsls_match_referee_if #(
  parameter int SCORE_W = 3
);
  logic               new_match;
  logic [2:0]         player1;
  logic [2:0]         player2;
  logic               move_valid;
  logic               move_ready;
  logic               round_valid;
  logic               p1wins;
  logic               p2wins;
  logic               tied;
  logic               invalid;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic               match_over;
  logic [1:0]         match_winner;
`ifdef RPSLS_TIE_LIMIT_EN
  logic [SCORE_W-1:0] tie_count;
`endif

  modport master (
    output new_match, player1, player2, move_valid,
    input  move_ready, round_valid,
    input  p1wins, p2wins, tied, invalid,
    input  p1_score, p2_score,
    input  match_over, match_winner
`ifdef RPSLS_TIE_LIMIT_EN
    , input tie_count
`endif
  );

  modport slave (
    input  new_match, player1, player2, move_valid,
    output move_ready, round_valid,
    output p1wins, p2wins, tied, invalid,
    output p1_score, p2_score,
    output match_over, match_winner
`ifdef RPSLS_TIE_LIMIT_EN
    , output tie_count
`endif
  );

endinterface

// File: rtl/rpsls_round_judge.sv
// Combinational single-round judge on two move codes.
// Exactly one of p1wins/p2wins/tied/invalid is high.
module rpsls_round_judge
  import rpsls_pkg::*;
(
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic       p1wins,
  output logic       p2wins,
  output logic       tied,
  output logic       invalid
);

  function automatic logic beats(
    logic [2:0] x,
    logic [2:0] y
  );
    case ({x, y})
      {ROCK, SCISSORS},
      {ROCK, LIZARD},
      {PAPER, ROCK},
      {PAPER, SPOCK},
      {SCISSORS, PAPER},
      {SCISSORS, LIZARD},
      {LIZARD, PAPER},
      {LIZARD, SPOCK},
      {SPOCK, ROCK},
      {SPOCK, SCISSORS}: return 1'b1;
      default:           return 1'b0;
    endcase
  endfunction

  logic bad;
  assign bad = !is_move(a) || !is_move(b);

  // Invalid outranks tie so equal bad codes never count as a tie.
  always_comb begin
    p1wins  = 1'b0;
    p2wins  = 1'b0;
    tied    = 1'b0;
    invalid = 1'b0;
    priority case (1'b1)
      bad:         invalid = 1'b1;
      (a == b):    tied    = 1'b1;
      beats(a, b): p1wins  = 1'b1;
      default:     p2wins  = 1'b1;
    endcase
  end

endmodule

// File: rtl/rpsls_match_referee.sv
// Multi-round RPSLS match referee with scores and match winner.
// Optional tie limit draw when RPSLS_TIE_LIMIT_EN is defined.
module rpsls_match_referee
  import rpsls_pkg::*;
#(
  parameter int ROUNDS_TO_WIN = 3,
  parameter int SCORE_W       = 3
`ifdef RPSLS_TIE_LIMIT_EN
  , parameter int MAX_TIES    = 4
`endif
) (
  input logic clk,
  input logic reset,
  rpsls_match_referee_if.slave bus
);

  localparam logic [SCORE_W-1:0] WIN_S = SCORE_W'(ROUNDS_TO_WIN);
  localparam logic [SCORE_W-1:0] ONE   = SCORE_W'(1);

  state_t             state;
  logic [2:0]         mv1;
  logic [2:0]         mv2;
  logic               rdy;
  logic               rv;
  logic [SCORE_W-1:0] s1;
  logic [SCORE_W-1:0] s2;
  logic               over;
  logic [1:0]         winner;
  logic [SCORE_W-1:0] s1_n;
  logic [SCORE_W-1:0] s2_n;
  logic               j_p1;
  logic               j_p2;
  logic               j_tie;
  logic               j_inv;

  rpsls_round_judge u_judge (
    .a       (mv1),
    .b       (mv2),
    .p1wins  (j_p1),
    .p2wins  (j_p2),
    .tied    (j_tie),
    .invalid (j_inv)
  );

  assign s1_n = s1 + ONE;
  assign s2_n = s2 + ONE;

`ifdef RPSLS_TIE_LIMIT_EN
  localparam logic [SCORE_W-1:0] TIE_S = SCORE_W'(MAX_TIES);
  logic [SCORE_W-1:0] ties;
  logic [SCORE_W-1:0] ties_n;
  assign ties_n        = ties + ONE;
  assign bus.tie_count = ties;
`endif

  // Match FSM: accept moves, judge, score, declare a winner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= READY;
      mv1    <= 3'd0;
      mv2    <= 3'd0;
      rdy    <= 1'b1;
      rv     <= 1'b0;
      s1     <= '0;
      s2     <= '0;
      over   <= 1'b0;
      winner <= W_NONE;
`ifdef RPSLS_TIE_LIMIT_EN
      ties   <= '0;
`endif
    end else if (bus.new_match) begin
      state  <= READY;
      rdy    <= 1'b1;
      rv     <= 1'b0;
      s1     <= '0;
      s2     <= '0;
      over   <= 1'b0;
      winner <= W_NONE;
`ifdef RPSLS_TIE_LIMIT_EN
      ties   <= '0;
`endif
    end else begin
      unique case (state)
        READY: begin
          if (bus.move_valid) begin
            mv1   <= bus.player1;
            mv2   <= bus.player2;
            rv    <= 1'b1;
            rdy   <= 1'b0;
            state <= RESULT;
          end
        end
        RESULT: begin
          rv    <= 1'b0;
          rdy   <= 1'b1;
          state <= READY;
          if (j_p1) begin
            s1 <= s1_n;
            if (s1_n == WIN_S) begin
              rdy    <= 1'b0;
              over   <= 1'b1;
              winner <= W_P1;
              state  <= DONE;
            end
          end else if (j_p2) begin
            s2 <= s2_n;
            if (s2_n == WIN_S) begin
              rdy    <= 1'b0;
              over   <= 1'b1;
              winner <= W_P2;
              state  <= DONE;
            end
          end
`ifdef RPSLS_TIE_LIMIT_EN
          else if (j_tie) begin
            ties <= ties_n;
            if (ties_n == TIE_S) begin
              rdy    <= 1'b0;
              over   <= 1'b1;
              winner <= W_DRAW;
              state  <= DONE;
            end
          end
`endif
        end
        DONE: begin
          rdy <= 1'b0;
        end
        default: begin
          rv    <= 1'b0;
          rdy   <= 1'b1;
          state <= READY;
        end
      endcase
    end
  end

  assign bus.move_ready   = rdy;
  assign bus.round_valid  = rv;
  assign bus.p1wins       = rv & j_p1;
  assign bus.p2wins       = rv & j_p2;
  assign bus.tied         = rv & j_tie;
  assign bus.invalid      = rv & j_inv;
  assign bus.p1_score     = s1;
  assign bus.p2_score     = s2;
  assign bus.match_over   = over;
  assign bus.match_winner = winner;

endmodule

// File: tb/tb_rpsls_match_referee.sv
// Self-checking bench for rpsls_match_referee.
// Directed steps plus random rounds against a modular-arithmetic model.
module tb_rpsls_match_referee;

  localparam int RTW = 3;
  localparam int SW  = 3;
  localparam int MT  = 4;

  logic clk;
  logic reset;

  rpsls_match_referee_if #(.SCORE_W(SW)) bus ();

`ifdef RPSLS_TIE_LIMIT_EN
  rpsls_match_referee #(
    .ROUNDS_TO_WIN(RTW),
    .SCORE_W(SW),
    .MAX_TIES(MT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );
`else
  rpsls_match_referee #(
    .ROUNDS_TO_WIN(RTW),
    .SCORE_W(SW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int passed = 0;
  int failed = 0;
  int total  = 0;

  int m_s1, m_s2, m_ties, m_win;
  bit m_over;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Position on the RPSLS wheel: R,K,P,L,S = 0..4.
  function automatic int wheel(input int c);
    case (c)
      1: return 0;
      5: return 1;
      2: return 2;
      4: return 3;
      3: return 4;
      default: return -1;
    endcase
  endfunction

  // 0 = p1 wins, 1 = p2 wins, 2 = tie, 3 = invalid
  function automatic int judge(input int a, input int b);
    int d;
    if (a < 1 || a > 5 || b < 1 || b > 5) return 3;
    if (a == b) return 2;
    d = (wheel(a) - wheel(b) + 5) % 5;
    return (d == 1 || d == 2) ? 0 : 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_s1 = 0; m_s2 = 0; m_ties = 0;
    m_over = 0; m_win = 0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_s1"}, bus.p1_score, m_s1);
    chk({tag, "_s2"}, bus.p2_score, m_s2);
    chk({tag, "_over"}, bus.match_over, m_over);
    chk({tag, "_win"}, bus.match_winner, m_win);
    chk({tag, "_rdy"}, bus.move_ready, !m_over);
`ifdef RPSLS_TIE_LIMIT_EN
    chk({tag, "_ties"}, bus.tie_count, m_ties);
`endif
  endtask

  task automatic newm();
    bus.new_match = 1'b1;
    step();
    bus.new_match = 1'b0;
    model_clear();
    chk("newm_rv", bus.round_valid, 0);
    chk_state("newm");
  endtask

  task automatic play(input int a, input int b);
    int e;
    bus.player1 = a[2:0];
    bus.player2 = b[2:0];
    bus.move_valid = 1'b1;
    step();
    bus.move_valid = 1'b0;
    e = judge(a, b);
    chk("res_rv", bus.round_valid, 1);
    chk("res_p1", bus.p1wins, e == 0);
    chk("res_p2", bus.p2wins, e == 1);
    chk("res_tie", bus.tied, e == 2);
    chk("res_inv", bus.invalid, e == 3);
    chk("res_rdy", bus.move_ready, 0);
    chk("res_s1", bus.p1_score, m_s1);
    chk("res_s2", bus.p2_score, m_s2);
    step();
    if (e == 0) begin
      m_s1++;
      if (m_s1 == RTW) begin m_over = 1; m_win = 1; end
    end else if (e == 1) begin
      m_s2++;
      if (m_s2 == RTW) begin m_over = 1; m_win = 2; end
    end else if (e == 2) begin
`ifdef RPSLS_TIE_LIMIT_EN
      m_ties++;
      if (m_ties == MT) begin m_over = 1; m_win = 3; end
`endif
    end
    chk("post_rv", bus.round_valid, 0);
    chk("post_flags",
        {bus.p1wins, bus.p2wins, bus.tied, bus.invalid}, 0);
    chk_state("post");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bus.new_match  = 1'b0;
    bus.player1    = 3'd0;
    bus.player2    = 3'd0;
    bus.move_valid = 1'b0;
    reset = 1'b1;
    model_clear();
    #2;
    chk("rst_rv", bus.round_valid, 0);
    chk("rst_flags",
        {bus.p1wins, bus.p2wins, bus.tied, bus.invalid}, 0);
    chk_state("rst");
    #10 reset = 1'b0;
    step();

    // rock beats scissors
    play(1, 3);
    chk("rs_s1", bus.p1_score, 1);
    newm();

    // lizard beats spock three times: match to p1
    repeat (3) play(4, 5);
    chk("lk_over", bus.match_over, 1);
    chk("lk_win", bus.match_winner, 1);
    chk("lk_rdy", bus.move_ready, 0);

    // move ignored in DONE
    bus.player1 = 3'd4;
    bus.player2 = 3'd5;
    bus.move_valid = 1'b1;
    step();
    bus.move_valid = 1'b0;
    chk("ign_rv", bus.round_valid, 0);
    step();
    chk("ign_rv2", bus.round_valid, 0);
    chk_state("ign");
    newm();

    // invalid codes, including equal invalid codes
    play(6, 2);
    play(0, 0);
    play(7, 7);
    play(3, 0);

    // tie
    play(2, 2);
    newm();

    // new_match blocks a simultaneous move
    bus.player1 = 3'd1;
    bus.player2 = 3'd3;
    bus.move_valid = 1'b1;
    bus.new_match = 1'b1;
    step();
    bus.move_valid = 1'b0;
    bus.new_match = 1'b0;
    model_clear();
    chk("nm_mv_rv", bus.round_valid, 0);
    step();
    chk("nm_mv_rv2", bus.round_valid, 0);
    chk_state("nm_mv");

    // new_match during RESULT drops the score
    bus.player1 = 3'd2;
    bus.player2 = 3'd1;
    bus.move_valid = 1'b1;
    step();
    bus.move_valid = 1'b0;
    chk("nmr_rv", bus.round_valid, 1);
    chk("nmr_p1", bus.p1wins, 1);
    bus.new_match = 1'b1;
    step();
    bus.new_match = 1'b0;
    chk("nmr_rv2", bus.round_valid, 0);
    chk_state("nmr");

`ifdef RPSLS_TIE_LIMIT_EN
    repeat (4) play(5, 5);
    chk("tl_ties", bus.tie_count, 4);
    chk("tl_over", bus.match_over, 1);
    chk("tl_win", bus.match_winner, 3);
    newm();
`else
    repeat (6) play(5, 5);
    chk("nt_over", bus.match_over, 0);
`endif

    // random rounds
    for (int i = 0; i < 80; i++) begin
      if (m_over) newm();
      play($urandom_range(0, 7), $urandom_range(0, 7));
    end

    // async reset mid-round
    if (m_over) newm();
    bus.player1 = 3'd3;
    bus.player2 = 3'd4;
    bus.move_valid = 1'b1;
    step();
    bus.move_valid = 1'b0;
    chk("ar_rv", bus.round_valid, 1);
    #2 reset = 1'b1;
    #1;
    model_clear();
    chk("ar_rv0", bus.round_valid, 0);
    chk("ar_flags",
        {bus.p1wins, bus.p2wins, bus.tied, bus.invalid}, 0);
    chk_state("ar");
    #2 reset = 1'b0;
    step();
    chk("ar_rv1", bus.round_valid, 0);
    play(3, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
